// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Shared types and constants for the serial byte collector.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    localparam int DEF_DATA_W = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_byte_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_byte_collector_if
// Description : Serial-in strobe bundle and parallel-out valid/ready bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_byte_collector_if
    import serial_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              serDin;
    logic              serValid;
    logic [DATA_W-1:0] outBus;
    logic              outValid;
    logic              outReady;
    logic              frameErr;
    logic              overrun;
    logic              clrOverrun;

    // Collector side: consumes the serial stream, produces the byte.
    modport slave (
        input  serDin, serValid, outReady, clrOverrun,
        output outBus, outValid, frameErr, overrun
    );

    modport master (
        output serDin, serValid, outReady, clrOverrun,
        input  outBus, outValid, frameErr, overrun
    );

endinterface : serial_byte_collector_if
`default_nettype wire

// File: rtl/serial_byte_collector_bit_shifter.sv
`default_nettype none
// ============================================================================
// Module      : bit_shifter
// Description : LSB-first shift register with bit counter and last-bit flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_shifter
    import serial_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_clr,
    input  wire logic              i_shift_en,
    input  wire logic              i_din,
    output logic      [DATA_W-1:0] o_data,
    output logic                   o_done
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_shift_en) begin
            r_data <= {i_din, r_data[DATA_W-1:1]};
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign o_data = r_data;
    // High while the next shift will be the final data bit of the frame.
    assign o_done = (r_cnt == CNT_W'(DATA_W - 1));

endmodule : bit_shifter
`default_nettype wire

// File: rtl/serial_byte_collector.sv
`default_nettype none
// ============================================================================
// Module      : serial_byte_collector
// Description : Frames a strobed serial stream into bytes with valid/ready out.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_byte_collector
    import serial_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    serial_byte_collector_if.slave  bus
);
    state_t            r_state;
    state_t            w_state_nxt;

    logic              w_clr;
    logic              w_shift;
    logic              w_good;
    logic              w_bad;
    logic              w_free;
    logic              w_load;
    logic              w_ovr_set;
    logic              w_done;
    logic [DATA_W-1:0] w_shift_data;

    logic [DATA_W-1:0] r_out_bus;
    logic              r_out_valid;
    logic              r_frame_err;
    logic              r_overrun;

    bit_shifter #(
        .DATA_W     (DATA_W)
    ) u_bit_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .i_shift_en (w_shift),
        .i_din      (bus.serDin),
        .o_data     (w_shift_data),
        .o_done     (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_shift     = 1'b0;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.serValid && (bus.serDin == START_BIT)) begin
                    w_clr       = 1'b1;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (bus.serValid) begin
                    w_shift = 1'b1;
                    if (w_done) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (bus.serValid) begin
                    w_state_nxt = IDLE;
                    if (bus.serDin == STOP_BIT) begin
                        w_good = 1'b1;
                    end else begin
                        w_bad  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The holding register may be refilled on the same edge it is consumed.
    assign w_free    = !r_out_valid || bus.outReady;
    assign w_load    = w_good && w_free;
    assign w_ovr_set = w_good && !w_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_bus   <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad;
            if (w_load) begin
                r_out_bus   <= w_shift_data;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && bus.outReady) begin
                r_out_valid <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (bus.clrOverrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.outBus   = r_out_bus;
    assign bus.outValid = r_out_valid;
    assign bus.frameErr = r_frame_err;
    assign bus.overrun  = r_overrun;

endmodule : serial_byte_collector
`default_nettype wire

// File: doc/serial_byte_collector.md
# serial_byte_collector

Upstream stage of the `BitWise` parity/all-ones checker. It receives a framed serial bit stream, strobed one bit at a time, and assembles each frame into a parallel byte. It presents the byte on `outBus` under a valid/ready handshake, so `outBus` can drive `BitWise.inputBus` directly. It also reports framing errors and overruns.

## Interface
Parameters:
- `DATA_W`, default 8: data bits per frame. `outBus` width must match the `BitWise` input width.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `serDin`  in  1  serial data line; idles high.
- `serValid`  in  1  bit strobe; `serDin` is sampled only on cycles where this is 1.
- `outBus`  out  DATA_W  assembled byte; bit 0 is the first data bit received.
- `outValid`  out  1  `outBus` holds an unconsumed byte.
- `outReady`  in  1  consumer accepts `outBus` on a cycle where `outValid && outReady`.
- `frameErr`  out  1  one-cycle pulse when a frame's stop bit is sampled as 0.
- `overrun`  out  1  sticky flag: a completed byte was dropped because the holding register was full.
- `clrOverrun`  in  1  clears `overrun`.

## Operation
- Frame format: one start bit (0), then DATA_W data bits LSB first, then one stop bit (1). Only strobed bits count.
- FSM states:
  - IDLE: a strobed 0 moves to DATA, clears the shift register and bit counter. A strobed 1 is ignored.
  - DATA: each strobed bit shifts in MSB-side, so after DATA_W bits, bit 0 of the shift register is the first data bit. The counter increments; after the DATA_W-th bit the FSM moves to STOP.
  - STOP:
    - Strobed 1: frame is good. If the holding register is free, or is being consumed in this same cycle, load `outBus` and set `outValid`. Otherwise keep the old byte, drop the new one, and set `overrun`. Return to IDLE.
    - Strobed 0: pulse `frameErr`, discard the byte, return to IDLE. `outBus`/`outValid` are unchanged.
- When `serValid` is 0, the FSM, counter and shift register hold.
- Handshake: `outValid` falls on the cycle after `outValid && outReady`, unless a new byte loads on that same edge; in that case `outValid` stays 1 and `outBus` takes the new byte. `outBus` is stable while `outValid` is 1 and not consumed.
- Overrun: if set and clear happen on the same edge, set wins. `clrOverrun` when `overrun` is 0 has no effect.
- Counter width: clog2(DATA_W+1). The counter never wraps within a frame.

## Timing
- Reset values: `outBus` = 0, `outValid` = 0, `frameErr` = 0, `overrun` = 0; FSM in IDLE, counter 0.
- Asserting `rst_n` mid-frame aborts the frame immediately, with no `frameErr` and no output. The first strobed 0 after release starts a new frame.
- Latency: `outValid` and the new `outBus` appear on the edge that samples the stop bit, and are visible the cycle after the stop-bit strobe.
- A minimum frame is DATA_W+2 strobed cycles; back-to-back frames are legal with no idle bits between them.
- `frameErr` is high for exactly one cycle, the cycle after the bad stop-bit strobe.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `serial_pkg`:
  - FSM state typedef (IDLE, DATA, STOP).
  - START_BIT = 0 and STOP_BIT = 1 constants.
  - Default DATA_W.
- One sub-module, `bit_shifter`: DATA_W-bit shift register with clear and shift-enable, plus a bit counter with a done flag. The top level holds the FSM, the holding register and the flags.
- The top level instantiates `bit_shifter` once. The system-level bench instantiates `serial_byte_collector` feeding `BitWise`.

## Test plan
- Frame with data 0x92 (bits 0,1,0,0,1,0,0,1), stop 1, `outReady` = 1 → `outBus` = 0x92, `outValid` pulses one cycle; downstream `BitWise` reports odd parity (3 ones).
- Frame 0xFF, then frame 0x96 back-to-back with `outReady` = 0 → `outBus` holds 0xFF, `overrun` = 1. `clrOverrun` → `overrun` = 0.
- Frame 0x55 with stop bit 0 → `frameErr` high for one cycle, `outValid` stays 0, FSM back in IDLE; a following good frame 0x0F → `outBus` = 0x0F.
- Frame 0xA5 with `serValid` gaps of 1–5 cycles between bits → `outBus` = 0xA5; strobed idle 1s before the start bit are ignored.
- `rst_n` low after 4 data bits → all outputs 0, no `frameErr`. Next full frame 0x3C → `outBus` = 0x3C.
- Stop bit of frame 0x81 sampled on the same cycle as `outValid && outReady` on byte 0x7E → `outValid` stays 1, `outBus` = 0x81, `overrun` stays 0.
